// File: rtl/usb_rx_packet_writer_pkg.sv
// usb_rx_packet_writer_pkg: PID constants, CRC16 constants and FSM encoding shared by the USB RX packet writer.
package usb_rx_packet_writer_pkg;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;
    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [3:0]  PID_DATA0      = 4'h3;
    localparam logic [3:0]  PID_DATA1      = 4'hB;
    typedef enum logic [2:0] {S_IDLE, S_DATA, S_HOLD, S_DROP, S_DROP_HELD} state_e;
    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid == PID_DATA0 || pid == PID_DATA1;
    endfunction
endpackage

// File: rtl/usb_rx_packet_writer_if.sv
// usb_rx_packet_writer_if: decoder/CPU-side signals of the RX packet writer; master drives the stream, slave is the writer.
interface usb_rx_packet_writer_if #(parameter int ADDR_W = 8);
    logic [7:0]        rx_byte;
    logic              rx_byte_valid;
    logic              rx_eop;
    logic              rx_error;
    logic              packet_ack;
    logic [ADDR_W-1:0] buf_write_address;
    logic [31:0]       buf_write_value;
    logic [3:0]        buf_write_sections;
    logic              packet_ready;
    logic [3:0]        packet_pid;
    logic [10:0]       packet_length;
    logic              packet_crc_ok;
    logic [7:0]        dropped_count;
    modport master (
        output rx_byte, rx_byte_valid, rx_eop, rx_error, packet_ack,
        input  buf_write_address, buf_write_value, buf_write_sections,
        input  packet_ready, packet_pid, packet_length, packet_crc_ok, dropped_count
    );
    modport slave (
        input  rx_byte, rx_byte_valid, rx_eop, rx_error, packet_ack,
        output buf_write_address, buf_write_value, buf_write_sections,
        output packet_ready, packet_pid, packet_length, packet_crc_ok, dropped_count
    );
endinterface

// File: rtl/usb_rx_packet_writer_crc16.sv
// usb_rx_packet_writer_crc16: one-byte combinational CRC16 step, reflected polynomial, LSB first.
module usb_rx_packet_writer_crc16
    import usb_rx_packet_writer_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);
    always_comb begin
        crc_o = crc_i ^ {8'h00, byte_i};
        for (int i = 0; i < 8; i++)
            crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC16_POLY) : (crc_o >> 1);
    end
endmodule

// File: rtl/usb_rx_packet_writer.sv
// usb_rx_packet_writer: validates PID, writes payload bytes into the packet buffer, checks CRC16 and holds the packet until acked.
module usb_rx_packet_writer
    import usb_rx_packet_writer_pkg::*;
#(
    parameter int BUFFER_BYTES = 1024,
    parameter int ADDR_W       = 8
) (
    input logic                    clk48,
    input logic                    rst_n,
    usb_rx_packet_writer_if.slave  bus
);
    state_e            state_q, state_d, st;
    logic [10:0]       count_q, count_d, len_q, len_d;
    logic [15:0]       crc_q, crc_d, crc_step;
    logic [3:0]        pid_q, pid_d, sec_q, sec_d;
    logic              ok_q, ok_d, ready_q, ready_d, enter_drop;
    logic [7:0]        drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       val_q, val_d;

    usb_rx_packet_writer_crc16 u_crc (.crc_i(crc_q), .byte_i(bus.rx_byte), .crc_o(crc_step));

    always_comb begin
        // An ack arriving in HOLD releases the packet in the same cycle, so a coincident byte is a fresh PID.
        st         = (state_q == S_HOLD && bus.packet_ack) ? S_IDLE : state_q;
        state_d    = st;
        ready_d    = ready_q && !(state_q == S_HOLD && bus.packet_ack);
        count_d    = count_q;
        crc_d      = crc_q;
        pid_d      = pid_q;
        len_d      = len_q;
        ok_d       = ok_q;
        sec_d      = 4'h0;
        addr_d     = addr_q;
        val_d      = val_q;
        enter_drop = 1'b0;
        case (st)
            S_IDLE: if (bus.rx_byte_valid) begin
                if (bus.rx_byte[3:0] == ~bus.rx_byte[7:4]) begin
                    pid_d   = bus.rx_byte[3:0];
                    count_d = 11'd0;
                    crc_d   = CRC16_INIT;
                    state_d = S_DATA;
                end else begin
                    enter_drop = 1'b1;
                    state_d    = bus.rx_eop ? S_IDLE : S_DROP;
                end
            end
            S_DATA: if (bus.rx_error) begin
                enter_drop = 1'b1;
                state_d    = S_DROP;
            end else if (bus.rx_byte_valid && count_q == 11'(BUFFER_BYTES)) begin
                enter_drop = 1'b1;
                state_d    = bus.rx_eop ? S_IDLE : S_DROP;
            end else begin
                if (bus.rx_byte_valid) begin
                    addr_d  = count_q[ADDR_W+1:2];
                    sec_d   = 4'b0001 << count_q[1:0];
                    val_d   = {4{bus.rx_byte}};
                    count_d = count_q + 11'd1;
                    crc_d   = crc_step;
                end
                if (bus.rx_eop) begin
                    len_d   = count_d;
                    ok_d    = is_data_pid(pid_q) ? (count_d >= 11'd2 && crc_d == CRC16_RESIDUAL) : 1'b1;
                    ready_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: if (bus.rx_byte_valid) begin
                enter_drop = 1'b1;
                state_d    = bus.rx_eop ? S_HOLD : S_DROP_HELD;
            end
            S_DROP:      state_d = bus.rx_eop ? S_IDLE : S_DROP;
            S_DROP_HELD: state_d = bus.rx_eop ? S_HOLD : S_DROP_HELD;
            default:     state_d = S_IDLE;
        endcase
        drop_d = drop_q + {7'd0, enter_drop && drop_q != 8'hFF};
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= 11'd0;
            crc_q   <= CRC16_INIT;
            pid_q   <= 4'h0;
            len_q   <= 11'd0;
            ok_q    <= 1'b0;
            ready_q <= 1'b0;
            drop_q  <= 8'h00;
            sec_q   <= 4'h0;
            addr_q  <= '0;
            val_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            crc_q   <= crc_d;
            pid_q   <= pid_d;
            len_q   <= len_d;
            ok_q    <= ok_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
            sec_q   <= sec_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
        end
    end

    assign bus.buf_write_address  = addr_q;
    assign bus.buf_write_value    = val_q;
    assign bus.buf_write_sections = sec_q;
    assign bus.packet_ready       = ready_q;
    assign bus.packet_pid         = pid_q;
    assign bus.packet_length      = len_q;
    assign bus.packet_crc_ok      = ok_q;
    assign bus.dropped_count      = drop_q;
endmodule

// File: tb/tb_usb_rx_packet_writer.sv
// tb_usb_rx_packet_writer: directed packets; buffer writes go through an expected-write queue checked by a monitor.
module tb_usb_rx_packet_writer;
    logic clk48 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk48 = ~clk48;

    usb_rx_packet_writer_if #(.ADDR_W(8)) bus ();
    usb_rx_packet_writer #(.BUFFER_BYTES(1024), .ADDR_W(8)) dut (.clk48(clk48), .rst_n(rst_n), .bus(bus));

    typedef struct packed {logic [7:0] a; logic [31:0] v; logic [3:0] s;} wr_t;
    wr_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic push_wr(input int idx, input logic [7:0] b);
        wr_t e;
        e.a = 8'(idx >> 2);
        e.v = {4{b}};
        e.s = 4'b0001 << (idx % 4);
        exp_q.push_back(e);
    endtask

    always @(negedge clk48) begin
        if (bus.buf_write_sections != 4'h0) begin
            if (exp_q.size() == 0) check("unexpected_write", {28'h0, bus.buf_write_sections}, 32'h0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {24'h0, bus.buf_write_address}, {24'h0, e.a});
                check("wr_value", bus.buf_write_value, e.v);
                check("wr_sections", {28'h0, bus.buf_write_sections}, {28'h0, e.s});
            end
        end
    end

    task automatic rx(input logic [7:0] b, input logic eop);
        bus.rx_byte = b;
        bus.rx_byte_valid = 1'b1;
        bus.rx_eop = eop;
        @(posedge clk48); #1;
        bus.rx_byte_valid = 1'b0;
        bus.rx_eop = 1'b0;
    endtask

    task automatic eop();
        bus.rx_eop = 1'b1;
        @(posedge clk48); #1;
        bus.rx_eop = 1'b0;
        @(posedge clk48); #1;
    endtask

    task automatic ack(input logic with_byte, input logic [7:0] b);
        bus.packet_ack = 1'b1;
        bus.rx_byte_valid = with_byte;
        bus.rx_byte = b;
        @(posedge clk48); #1;
        bus.packet_ack = 1'b0;
        bus.rx_byte_valid = 1'b0;
    endtask

    task automatic status(input string t, input logic r, input logic [3:0] p, input logic [10:0] l,
                          input logic ok, input logic [7:0] d);
        check({t, "_ready"}, {31'h0, bus.packet_ready}, {31'h0, r});
        check({t, "_pid"}, {28'h0, bus.packet_pid}, {28'h0, p});
        check({t, "_length"}, {21'h0, bus.packet_length}, {21'h0, l});
        check({t, "_crc_ok"}, {31'h0, bus.packet_crc_ok}, {31'h0, ok});
        check({t, "_dropped"}, {24'h0, bus.dropped_count}, {24'h0, d});
    endtask

    // CRC16 over 01 02 03 leaves 0x6161 in the register; its complement goes out LSB first as 9E 9E.
    logic [7:0] good_pkt [5] = '{8'h01, 8'h02, 8'h03, 8'h9E, 8'h9E};

    initial begin
        bus.rx_byte = 8'h00;
        bus.rx_byte_valid = 1'b0;
        bus.rx_eop = 1'b0;
        bus.rx_error = 1'b0;
        bus.packet_ack = 1'b0;
        repeat (2) @(posedge clk48);
        #1;
        status("reset", 1'b0, 4'h0, 11'd0, 1'b0, 8'd0);
        check("reset_sections", {28'h0, bus.buf_write_sections}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk48); #1;

        rx(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_wr(i, good_pkt[i]);
            rx(good_pkt[i], 1'b0);
        end
        eop();
        status("good_crc", 1'b1, 4'h3, 11'd5, 1'b1, 8'd0);

        rx(8'hC3, 1'b0);
        rx(8'hAA, 1'b0);
        eop();
        status("held_keep", 1'b1, 4'h3, 11'd5, 1'b1, 8'd1);
        ack(1'b0, 8'h00);
        check("held_acked_ready", {31'h0, bus.packet_ready}, 32'h0);

        rx(8'hC3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_wr(i, good_pkt[i]);
            rx(good_pkt[i], 1'b0);
        end
        push_wr(4, 8'h9F);
        rx(8'h9F, 1'b1);
        @(posedge clk48); #1;
        status("bad_crc", 1'b1, 4'h3, 11'd5, 1'b0, 8'd1);
        ack(1'b0, 8'h00);

        rx(8'hC3, 1'b0);
        push_wr(0, 8'hAA);
        rx(8'hAA, 1'b0);
        eop();
        status("short_data", 1'b1, 4'h3, 11'd1, 1'b0, 8'd1);
        ack(1'b1, 8'hD2);
        eop();
        status("ack_with_pid", 1'b1, 4'h2, 11'd0, 1'b1, 8'd1);
        ack(1'b0, 8'h00);

        rx(8'hC4, 1'b0);
        rx(8'h01, 1'b0);
        rx(8'h02, 1'b0);
        rx(8'h03, 1'b0);
        eop();
        check("bad_pid_ready", {31'h0, bus.packet_ready}, 32'h0);
        check("bad_pid_dropped", {24'h0, bus.dropped_count}, 32'd2);

        rx(8'hC3, 1'b0);
        for (int i = 0; i < 1025; i++) begin
            if (i < 1024) push_wr(i, 8'(i));
            rx(8'(i), 1'b0);
        end
        eop();
        check("overflow_ready", {31'h0, bus.packet_ready}, 32'h0);
        check("overflow_dropped", {24'h0, bus.dropped_count}, 32'd3);
        check("overflow_writes_left", exp_q.size(), 32'd0);

        rx(8'hC3, 1'b0);
        push_wr(0, 8'h11);
        rx(8'h11, 1'b0);
        push_wr(1, 8'h22);
        rx(8'h22, 1'b0);
        @(negedge clk48); #1;
        rst_n = 1'b0;
        #1;
        status("async_reset", 1'b0, 4'h0, 11'd0, 1'b0, 8'd0);
        check("async_reset_sections", {28'h0, bus.buf_write_sections}, 32'h0);
        check("async_reset_value", bus.buf_write_value, 32'h0);
        check("async_reset_addr", {24'h0, bus.buf_write_address}, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk48); #1;
        rx(8'hD2, 1'b0);
        eop();
        status("post_reset_ack", 1'b1, 4'h2, 11'd0, 1'b1, 8'd0);
        ack(1'b0, 8'h00);
        check("post_reset_acked", {31'h0, bus.packet_ready}, 32'h0);

        repeat (2) @(posedge clk48);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
